// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the mc_cpu multicycle core: encodings, FSM states
// and the instruction field layout.
package mc_cpu_pkg;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam int IMM8_W = 8;
  localparam int IMM5_W = 5;
  localparam int INSN_W = 16;

  typedef enum logic [2:0] {S_IF, S_DEC, S_EX, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_MVN, ALU_PASS} alu_op_t;

  // Field view of the 16-bit instruction word; imm8/imm5 overlay the low bits.
  typedef struct packed {
    logic [2:0] opc;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } instr_t;

endpackage

// File: rtl/mc_cpu_alu.sv
// Combinational operand shifter and ALU; flags always describe a - sh(b).
module mc_cpu_alu
  import mc_cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_sh,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_res,
  output logic             o_n,
  output logic             o_v,
  output logic             o_z
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_diff;

  always_comb begin
    unique case (i_sh)
      SH_LSL:  w_b = {i_b[WIDTH-2:0], 1'b0};
      SH_LSR:  w_b = {1'b0, i_b[WIDTH-1:1]};
      SH_ASR:  w_b = {i_b[WIDTH-1], i_b[WIDTH-1:1]};
      default: w_b = i_b;
    endcase
  end

  assign w_diff = i_a - w_b;

  always_comb begin
    case (alu_op_t'(i_op))
      ALU_ADD: o_res = i_a + w_b;
      ALU_SUB: o_res = w_diff;
      ALU_AND: o_res = i_a & w_b;
      ALU_MVN: o_res = ~w_b;
      default: o_res = w_b;
    endcase
  end

  // Overflow of a - b: operands differ in sign and the result left a's sign.
  assign o_z = (w_diff == '0);
  assign o_n = w_diff[WIDTH-1];
  assign o_v = (i_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/mc_cpu.sv
// Multicycle CPU: fetches 16-bit instructions through a req/ready memory port
// and walks IF/DEC/EX/MEM/WB with a width-generic datapath.
module mc_cpu
  import mc_cpu_pkg::*;
#(
  parameter int              WIDTH    = 16,
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ready,
  output logic [WIDTH-1:0]  out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              halted
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  instr_t            r_ir;
  logic [WIDTH-1:0]  r_regs [8];
  logic [WIDTH-1:0]  r_res;
  logic [WIDTH-1:0]  r_out;
  logic              r_n, r_v, r_z;
  logic              r_halted;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WIDTH-1:0]  r_mem_wdata;

  logic             w_mov_imm, w_mov_reg, w_alu, w_cmp, w_ldr, w_str, w_mem_op;
  logic [WIDTH-1:0] w_imm8_sx, w_imm5_sx;
  logic [WIDTH-1:0] w_alu_b, w_alu_res;
  logic [1:0]       w_alu_sh;
  alu_op_t          w_alu_op;
  logic             w_n, w_v, w_z;
  logic [2:0]       w_dst;

  assign w_mov_imm = (r_ir.opc == OPC_MOV) && (r_ir.op == OP_MOV_IMM);
  assign w_mov_reg = (r_ir.opc == OPC_MOV) && (r_ir.op == OP_MOV_REG);
  assign w_alu     = (r_ir.opc == OPC_ALU);
  assign w_cmp     = w_alu && (r_ir.op == OP_CMP);
  assign w_ldr     = (r_ir.opc == OPC_LDR) && (r_ir.op == OP_MEM);
  assign w_str     = (r_ir.opc == OPC_STR) && (r_ir.op == OP_MEM);
  assign w_mem_op  = w_ldr || w_str;

  assign w_imm8_sx = {{(WIDTH-IMM8_W){r_ir[IMM8_W-1]}}, r_ir[IMM8_W-1:0]};
  assign w_imm5_sx = {{(WIDTH-IMM5_W){r_ir[IMM5_W-1]}}, r_ir[IMM5_W-1:0]};
  assign w_dst     = w_mov_imm ? r_ir.rn : r_ir.rd;

  // Loads/stores reuse the adder for Rn + sx(imm5), with no operand shift.
  assign w_alu_b  = w_mem_op ? w_imm5_sx : r_regs[r_ir.rm];
  assign w_alu_sh = w_mem_op ? SH_NONE : r_ir.sh;

  always_comb begin
    w_alu_op = ALU_PASS;
    if (w_mem_op) begin
      w_alu_op = ALU_ADD;
    end else if (w_alu) begin
      case (r_ir.op)
        OP_ADD:  w_alu_op = ALU_ADD;
        OP_CMP:  w_alu_op = ALU_SUB;
        OP_AND:  w_alu_op = ALU_AND;
        default: w_alu_op = ALU_MVN;
      endcase
    end
  end

  mc_cpu_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a   (r_regs[r_ir.rn]),
    .i_b   (w_alu_b),
    .i_sh  (w_alu_sh),
    .i_op  (w_alu_op),
    .o_res (w_alu_res),
    .o_n   (w_n),
    .o_v   (w_v),
    .o_z   (w_z)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IF;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      r_res       <= '0;
      r_out       <= '0;
      r_n         <= 1'b0;
      r_v         <= 1'b0;
      r_z         <= 1'b0;
      r_halted    <= 1'b0;
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= RESET_PC;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        S_IF: begin
          if (mem_ready) begin
            r_ir      <= instr_t'(mem_rdata[INSN_W-1:0]);
            r_pc      <= r_pc + ADDR_W'(1);
            r_mem_req <= 1'b0;
            r_state   <= S_DEC;
          end
        end
        S_DEC: begin
          if (w_mov_imm) begin
            r_res   <= w_imm8_sx;
            r_state <= S_WB;
          end else if (w_mov_reg || w_alu || w_mem_op) begin
            r_state <= S_EX;
          end else if (r_ir.opc == OPC_HALT) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
            r_state    <= S_IF;
          end
        end
        S_EX: begin
          r_res <= w_alu_res;
          if (w_cmp) begin
            r_n        <= w_n;
            r_v        <= w_v;
            r_z        <= w_z;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
            r_state    <= S_IF;
          end else if (w_mem_op) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= w_str;
            r_mem_addr <= w_alu_res[ADDR_W-1:0];
            if (w_str) r_mem_wdata <= r_regs[r_ir.rd];
            r_state    <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (w_ldr) begin
              r_res     <= mem_rdata;
              r_mem_req <= 1'b0;
              r_state   <= S_WB;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= r_pc;
              r_state    <= S_IF;
            end
          end
        end
        S_WB: begin
          r_regs[w_dst] <= r_res;
          r_out         <= r_res;
          r_mem_req     <= 1'b1;
          r_mem_we      <= 1'b0;
          r_mem_addr    <= r_pc;
          r_state       <= S_IF;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IF;
      endcase
    end
  end

  // The request is forced low while reset is held so an in-flight access is dropped at once.
  assign mem_req   = r_mem_req & ~reset;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign out       = r_out;
  assign N         = r_n;
  assign V         = r_v;
  assign Z         = r_z;
  assign halted    = r_halted;

endmodule

// File: tb/tb_mc_cpu.sv
// Random-program bench for mc_cpu: an instruction-level model predicts every
// bus transaction, per-instruction cycle count and the architectural outputs.
module tb_mc_cpu;

  localparam int W  = 16;
  localparam int AW = 8;
  localparam logic [AW-1:0] RPC = 8'hFE;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic [W-1:0]  out;
  logic          N, V, Z, halted;

  always #5 clk = ~clk;

  mc_cpu #(.WIDTH(W), .ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .out       (out),
    .N         (N),
    .V         (V),
    .Z         (Z),
    .halted    (halted)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image and instruction-level model state
  logic [W-1:0]  mem [256];
  logic [W-1:0]  m_r [8];
  logic [AW-1:0] m_pc;
  logic [W-1:0]  m_out;
  logic          m_n, m_v, m_z;
  bit            m_halt;
  bit            exp_data, exp_we;
  logic [AW-1:0] exp_addr;
  logic [W-1:0]  exp_wdata;
  logic [2:0]    exp_rd;
  int            exp_cycles, cyc_since, waits, n_ins, ins_limit;
  bit            first, p_valid, p_we, rst_arm, want_rst;
  logic [AW-1:0] p_addr;
  logic [W-1:0]  p_wdata;

  function automatic logic [15:0] enc_r(input logic [2:0] opc, input logic [1:0] op,
                                        input logic [2:0] rn, input logic [2:0] rd,
                                        input logic [1:0] sh, input logic [2:0] rm);
    return {opc, op, rn, rd, sh, rm};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] rn, input logic [7:0] imm);
    return {5'b11010, rn, imm};
  endfunction

  function automatic logic [15:0] rand_ins();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 10))
      0, 1:    r[15:11] = 5'b11010;
      2:       r[15:11] = 5'b11000;
      3, 4, 5: r[15:13] = 3'b101;
      6, 7:    r[15:11] = 5'b01100;
      8:       r[15:11] = 5'b10000;
      9:       r[15:11] = 5'b01101;
      default: r[15:13] = 3'($urandom_range(0, 2));
    endcase
    return r;
  endfunction

  function automatic logic [15:0] shv(input logic [15:0] x, input logic [1:0] s);
    case (s)
      2'd1:    return x << 1;
      2'd2:    return x >> 1;
      2'd3:    return 16'($signed(x) >>> 1);
      default: return x;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_pc = RPC; m_out = '0; m_n = 0; m_v = 0; m_z = 0; m_halt = 0;
    exp_data = 0; first = 1; cyc_since = 0; waits = 0; p_valid = 0;
  endtask

  task automatic model_exec(input logic [15:0] ins);
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op, sh;
    logic [15:0] a, b, res, ea;
    int d;
    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
    rd = ins[7:5]; sh = ins[4:3]; rm = ins[2:0];
    a  = m_r[rn];
    b  = shv(m_r[rm], sh);
    ea = a + {{11{ins[4]}}, ins[4:0]};
    exp_cycles = 2;
    if (opc == 3'b110 && op == 2'b10) begin
      m_r[rn] = {{8{ins[7]}}, ins[7:0]}; m_out = m_r[rn]; exp_cycles = 3;
    end else if (opc == 3'b110 && op == 2'b00) begin
      m_r[rd] = b; m_out = b; exp_cycles = 4;
    end else if (opc == 3'b101 && op == 2'b01) begin
      d = int'($signed(a)) - int'($signed(b));
      res = d[15:0];
      m_z = (res == 16'h0); m_n = res[15]; m_v = (d > 32767) || (d < -32768);
      exp_cycles = 3;
    end else if (opc == 3'b101) begin
      res = (op == 2'b00) ? a + b : (op == 2'b10) ? (a & b) : ~b;
      m_r[rd] = res; m_out = res; exp_cycles = 4;
    end else if (opc == 3'b011 && op == 2'b00) begin
      exp_data = 1; exp_we = 0; exp_addr = ea[7:0]; exp_rd = rd; exp_cycles = 5;
    end else if (opc == 3'b100 && op == 2'b00) begin
      exp_data = 1; exp_we = 1; exp_addr = ea[7:0]; exp_wdata = m_r[rd]; exp_cycles = 4;
    end else if (opc == 3'b111) begin
      m_halt = 1;
    end
  endtask

  task automatic load_program(input bit with_pro);
    logic [15:0] pro [16];
    pro[0]  = enc_i(3'd0, 8'd5);
    pro[1]  = enc_i(3'd1, 8'hFD);
    pro[2]  = enc_i(3'd1, 8'd3);
    pro[3]  = enc_r(3'b101, 2'b00, 3'd0, 3'd2, 2'b01, 3'd1);
    pro[4]  = enc_r(3'b101, 2'b01, 3'd0, 3'd0, 2'b00, 3'd0);
    pro[5]  = enc_i(3'd4, 8'hFF);
    pro[6]  = enc_r(3'b101, 2'b11, 3'd0, 3'd4, 2'b10, 3'd4);
    pro[7]  = enc_i(3'd5, 8'd1);
    pro[8]  = enc_r(3'b101, 2'b01, 3'd4, 3'd0, 2'b00, 3'd5);
    pro[9]  = enc_i(3'd1, 8'h40);
    pro[10] = enc_r(3'b100, 2'b00, 3'd1, 3'd0, 2'b00, 3'd2);
    pro[11] = enc_r(3'b011, 2'b00, 3'd1, 3'd3, 2'b00, 3'd2);
    pro[12] = 16'h0000;
    pro[13] = enc_i(3'd6, 8'h80);
    pro[14] = enc_r(3'b110, 2'b00, 3'd0, 3'd7, 2'b11, 3'd6);
    pro[15] = enc_r(3'b101, 2'b10, 3'd7, 3'd2, 2'b00, 3'd0);
    for (int i = 0; i < 256; i++) mem[i] = rand_ins();
    if (with_pro) for (int k = 0; k < 16; k++) mem[RPC + 8'(k)] = pro[k];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    check_val("rst_req_now", mem_req, 0);
    @(posedge clk);
    @(negedge clk);
    check_val("rst_req", mem_req, 0);
    check_val("rst_bus", {mem_we, mem_addr, mem_wdata}, {1'b0, RPC, 16'h0});
    check_val("rst_out", out, 0);
    check_val("rst_flags", {N, V, Z, halted}, 0);
    reset = 1'b0;
    mem_ready = 1'b0;
    model_reset();
  endtask

  // One clock of bus service; the handshake decided here completes on the next rising edge.
  task automatic tick();
    bit rdy;
    @(negedge clk);
    cyc_since++;
    mem_rdata = 16'($urandom);
    if (m_halt) begin
      check_val("halt_req", mem_req, 0);
      check_val("halted", halted, (cyc_since >= 2) ? 1 : 0);
      mem_ready = 1'($urandom_range(0, 1));
      return;
    end
    if (p_valid) begin
      check_val("req_held", mem_req, 1);
      check_val("bus_held", {mem_we, mem_addr, mem_we ? mem_wdata : 16'h0},
                {p_we, p_addr, p_we ? p_wdata : 16'h0});
    end
    if (!mem_req) begin
      mem_ready = 1'($urandom_range(0, 1));
      p_valid = 0;
      return;
    end
    rdy = ($urandom_range(0, 3) != 0);
    mem_ready = rdy;
    if (!rdy) begin
      waits++;
      p_valid = 1; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
      if (rst_arm && exp_data && !exp_we) want_rst = 1;
      return;
    end
    p_valid = 0;
    if (exp_data) begin
      check_val("data_we", mem_we, exp_we);
      check_val("data_addr", mem_addr, exp_addr);
      if (exp_we) begin
        check_val("st_wdata", mem_wdata, exp_wdata);
        mem[exp_addr] = exp_wdata;
      end else begin
        mem_rdata = mem[exp_addr];
        m_r[exp_rd] = mem_rdata;
        m_out = mem_rdata;
      end
      exp_data = 0;
    end else begin
      check_val("if_we", mem_we, 0);
      check_val("fetch_pc", mem_addr, m_pc);
      check_val("run_halted", halted, 0);
      check_val("out", out, m_out);
      check_val("nvz", {N, V, Z}, {m_n, m_v, m_z});
      if (!first) check_val("cycles", cyc_since, exp_cycles + waits);
      first = 0; cyc_since = 0; waits = 0; n_ins++;
      if (n_ins >= ins_limit) mem[m_pc] = 16'hE000;
      mem_rdata = mem[m_pc];
      m_pc++;
      model_exec(mem_rdata);
    end
  endtask

  task automatic run_phase(input int limit, input bit arm);
    int budget;
    budget = 20000; ins_limit = limit; n_ins = 0; rst_arm = arm; want_rst = 0;
    while (!(m_halt && cyc_since >= 22) && budget > 0) begin
      tick();
      if (want_rst) begin
        want_rst = 0;
        rst_arm = 0;
        do_reset();
      end
      budget--;
    end
    check_val("halt_reached", m_halt, 1);
  endtask

  initial begin
    load_program(1'b1);
    do_reset();
    run_phase(200, 1'b0);
    load_program(1'b0);
    do_reset();
    run_phase(200, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
